// File: rtl/dioptase_pkg.sv
// ---------------------------------------------------------------------------
// dioptase_pkg
// Shared definitions for the fetch-to-decode instruction queue.
//   INSTR_W / PC_W / EXC_W : default widths of an instruction, its PC and
//                            its fetch-side exception code
//   EXC_NONE               : exception code meaning "no exception"
//   iq_entry_t             : one queue entry {instr, pc, exc} at default widths
// ---------------------------------------------------------------------------
package dioptase_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int EXC_W   = 8;

    localparam logic [EXC_W-1:0] EXC_NONE = 8'h00;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [EXC_W-1:0]   exc;
    } iq_entry_t;

endpackage : dioptase_pkg

// File: rtl/instr_queue_if.sv
// ---------------------------------------------------------------------------
// instr_queue_if
// Bundle of every non-clock/reset signal between the pipeline and the
// instruction queue.
//   master : pipeline side (fetch + decode + pipeline control) -- drives
//            clk_en, halt, flush, in_valid, in_instr, in_pc, in_exc, stall;
//            receives in_ready, out_bubble, out_instr, out_pc, out_exc,
//            count, hwm
//   slave  : the queue itself (directions mirrored)
// ---------------------------------------------------------------------------
interface instr_queue_if #(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = dioptase_pkg::INSTR_W,
    parameter int PC_W    = dioptase_pkg::PC_W,
    parameter int EXC_W   = dioptase_pkg::EXC_W
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // pipeline control
    logic               clk_en;
    logic               halt;
    logic               flush;

    // fetch side
    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic [EXC_W-1:0]   in_exc;
    logic               in_ready;

    // decode side
    logic               stall;
    logic               out_bubble;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [EXC_W-1:0]   out_exc;

    // status
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   hwm;

    modport master (
        output clk_en, halt, flush,
        output in_valid, in_instr, in_pc, in_exc,
        input  in_ready,
        output stall,
        input  out_bubble, out_instr, out_pc, out_exc,
        input  count, hwm
    );

    modport slave (
        input  clk_en, halt, flush,
        input  in_valid, in_instr, in_pc, in_exc,
        output in_ready,
        input  stall,
        output out_bubble, out_instr, out_pc, out_exc,
        output count, hwm
    );

endinterface : instr_queue_if

// File: rtl/instr_queue_ram.sv
// ---------------------------------------------------------------------------
// instr_queue_ram
// DEPTH x WIDTH entry storage for the instruction queue. Synchronous write,
// asynchronous read so the head entry is visible in the same cycle the read
// pointer points at it. Contents are never reset; validity is tracked by the
// queue pointers only.
//   clk        : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_addr_i  : read address
//   rd_data_o  : read data (combinational)
// ---------------------------------------------------------------------------
module instr_queue_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 72,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : instr_queue_ram

// File: rtl/instr_queue.sv
// ---------------------------------------------------------------------------
// instr_queue
// Fetch-to-decode instruction queue. Holds up to DEPTH fetched instructions
// (with PC and fetch exception code) and presents the oldest one to decode.
// Supports flush, decode stall, halt and a global clock enable, and reports
// occupancy plus a high-water mark since reset/flush.
//
// Ports
//   clk    : pipeline clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   q      : instr_queue_if.slave -- control, fetch, decode and status signals
//
// Build option
//   INSTR_QUEUE_BYPASS_EN : when defined, an instruction arriving at an empty
//   queue is shown to decode in the same cycle; if decode takes it (active,
//   no stall) it is never written. When undefined there is no combinational
//   path from in_* to out_* and latency is one cycle.
// ---------------------------------------------------------------------------
module instr_queue #(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = dioptase_pkg::INSTR_W,
    parameter int PC_W    = dioptase_pkg::PC_W,
    parameter int EXC_W   = dioptase_pkg::EXC_W
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_queue_if.slave  q
);
    import dioptase_pkg::*;

    localparam int AW      = $clog2(DEPTH);
    localparam int PTR_W   = AW + 1;          // extra MSB is the wrap bit
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = INSTR_W + PC_W + EXC_W;

    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   hwm_q, hwm_d;
    logic [CNT_W-1:0]   count_d;

    logic               active;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               bypass_hit;   // outputs are driven from in_*
    logic               bypass_take;  // decode consumes the bypassed word

    logic [ENTRY_W-1:0] head_entry;
    logic [INSTR_W-1:0] head_instr;
    logic [PC_W-1:0]    head_pc;
    logic [EXC_W-1:0]   head_exc;

    // -----------------------------------------------------------------------
    // Flags
    // -----------------------------------------------------------------------
    assign active = q.clk_en && !q.halt;
    assign empty  = (rd_ptr_q == wr_ptr_q);
    assign full   = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) &&
                    (rd_ptr_q[AW] != wr_ptr_q[AW]);

    assign q.in_ready = !full;

`ifdef INSTR_QUEUE_BYPASS_EN
    assign bypass_hit  = empty && q.in_valid && !q.flush;
    assign bypass_take = bypass_hit && active && !q.stall;
`else
    assign bypass_hit  = 1'b0;
    assign bypass_take = 1'b0;
`endif

    // A bypassed word that decode takes is never written to storage.
    assign push = active && q.in_valid && !full && !q.flush && !bypass_take;
    // Pop only real stored entries; a bypassed word does not move rd_ptr.
    assign pop  = active && !empty && !q.stall && !q.flush;

    // -----------------------------------------------------------------------
    // Next-state: pointers and high-water mark
    // -----------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        hwm_d    = hwm_q;
        count_d  = CNT_W'(wr_ptr_q - rd_ptr_q);
        if (active) begin
            if (q.flush) begin
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                hwm_d    = '0;
                count_d  = '0;
            end else begin
                if (push) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                count_d = CNT_W'(wr_ptr_d - rd_ptr_d);
                if (count_d > hwm_q) begin
                    hwm_d = count_d;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            hwm_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            hwm_q    <= hwm_d;
        end
    end

    assign q.count = CNT_W'(wr_ptr_q - rd_ptr_q);
    assign q.hwm   = hwm_q;

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    instr_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (push),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i ({q.in_instr, q.in_pc, q.in_exc}),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (head_entry)
    );

    assign {head_instr, head_pc, head_exc} = head_entry;

    // -----------------------------------------------------------------------
    // Decode-side outputs: zeros on a bubble so decode never sees stale data
    // -----------------------------------------------------------------------
    always_comb begin
        q.out_bubble = 1'b1;
        q.out_instr  = '0;
        q.out_pc     = '0;
        q.out_exc    = EXC_W'(EXC_NONE);
        if (bypass_hit) begin
            q.out_bubble = 1'b0;
            q.out_instr  = q.in_instr;
            q.out_pc     = q.in_pc;
            q.out_exc    = q.in_exc;
        end else if (!empty) begin
            q.out_bubble = 1'b0;
            q.out_instr  = head_instr;
            q.out_pc     = head_pc;
            q.out_exc    = head_exc;
        end
    end

endmodule : instr_queue

// File: doc/instr_queue.md
# instr_queue

Parametrised fetch-to-decode instruction queue replacing the two-deep stall-replay buffer in the decode stage. It holds up to DEPTH fetched instructions, each with its PC and fetch-side exception code, and presents the oldest one to decode. The design has flush, stall, halt and clock-enable semantics matching the pipeline, plus occupancy and high-water-mark status. It sits between the instruction-memory response port and decode.

## Interface
- DEPTH, 4: entry count; power of two, ≥2
- INSTR_W, 32: instruction width
- PC_W, 32: PC width
- EXC_W, 8: exception code width
- CNT_W, $clog2(DEPTH+1): occupancy width (derived)
- clk  in  1  pipeline clock; one clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clk_en  in  1  global clock enable; state frozen when 0
- halt  in  1  freeze; state frozen when 1
- flush  in  1  discard all entries and this cycle's push
- in_valid  in  1  fetch presents an instruction
- in_instr  in  INSTR_W  fetched word
- in_pc  in  PC_W  its PC
- in_exc  in  EXC_W  fetch exception (0 = none)
- in_ready  out  1  queue accepts a push
- stall  in  1  decode cannot consume this cycle
- out_bubble  out  1  no valid entry presented
- out_instr  out  INSTR_W  oldest instruction (0 when bubble)
- out_pc  out  PC_W  its PC (0 when bubble)
- out_exc  out  EXC_W  its exception (0 when bubble)
- count  out  CNT_W  current occupancy
- hwm  out  CNT_W  peak occupancy since reset/flush

## Operation
- active = clk_en && !halt. No state changes when inactive; outputs stay combinationally consistent with held state.
- Pointers rd_ptr and wr_ptr are $clog2(DEPTH)+1 bits wide, and the MSB is the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSB differs.
  - count = wr_ptr − rd_ptr, modulo 2^(ptr width).
- in_ready = !full. It does not depend on stall or pop.
- push = active && in_valid && in_ready && !flush. It writes {in_instr,in_pc,in_exc} at wr_ptr and increments wr_ptr.
- pop = active && !out_bubble && !stall && !flush. It increments rd_ptr.
- Push and pop in the same cycle: both occur and count is unchanged. This is legal at any non-full count, including count 1.
- Flush (when active): rd_ptr, wr_ptr and hwm are cleared on the next edge. The flush overrides push and pop.
- Flush is ignored when inactive.
- hwm is updated to max(hwm, next count) every active edge.
- Entry contents are not cleared by reset or flush. Only the pointers define validity.

## Timing
- Reset values: rd_ptr=wr_ptr=0, hwm=0, count=0, out_bubble=1, out_instr/out_pc/out_exc=0, in_ready=1.
- Latency without bypass: an instruction pushed at edge N appears at outputs after edge N, so decode sees it in cycle N+1.
- Throughput: one push and one pop per cycle.
- Wrap-around: pointers roll over naturally. Ordering is preserved across the wrap.
- Reset asserted mid-operation: all state clears immediately and asynchronously. In-flight entries are lost.
- Full with in_valid=1: no push occurs, and fetch must hold its request.

## Configuration
- INSTR_QUEUE_BYPASS_EN defined: when empty && in_valid && !flush, outputs equal the in_* values combinationally and out_bubble=0.
  - If additionally !stall && active, the instruction is consumed without being written, and the pointers do not move.
  - If stall, it is written normally.
  - Latency is 0 cycles.
- Undefined: no combinational path from in_* to out_*, and latency is 1 cycle as above.

## Structure
- dioptase_pkg holds INSTR_W, PC_W and EXC_W defaults, the EXC_NONE=8'h00 constant, and the queue entry struct {instr, pc, exc}.
- One sub-module, instr_queue_ram: a DEPTH×entry storage array with a synchronous write port and an asynchronous read port.
- Pointer, flag, hwm and bypass logic live in instr_queue.

## Test plan
- Reset, then push 0xA000_0001 with pc 0x100 and hold stall=0. The entry appears with out_bubble=0 next cycle; the queue is empty after the pop, and count/hwm are 1 then 0/1.
- With stall=1, push DEPTH=4 words. count reaches 4, in_ready=0 and hwm=4; a fifth in_valid is not accepted. Then release stall: the words emerge in order over 4 cycles.
- Hold flush for one cycle at count=3 with in_valid=1. Next cycle count=0, hwm=0 and out_bubble=1; the flushed input is absent.
- Run continuous push and pop for 20 cycles with incrementing PCs 0x0, 0x4, ... The outputs are in order across pointer wrap and count stays at 1.
- Push an entry with in_exc=8'h80 and pc 0x40. It emerges with out_exc=8'h80; neighbouring entries show out_exc=0.
- With halt=1 (also with clk_en=0), drive push and pop requests. Pointers, count and outputs are unchanged. With INSTR_QUEUE_BYPASS_EN, an empty queue with in_valid=1 shows in_instr on out_instr in the same cycle.
